// File: rtl/waveram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// waveram_arbiter_pkg : wavetable address/sample geometry shared with the NCO
// Revision 1.0
// ============================================================================
package waveram_arbiter_pkg;

    localparam int WAVE_FIELD_WIDTH   = 6;
    localparam int SAMPLE_FIELD_WIDTH = 7;
    localparam int ADDR_WIDTH_DEF     = WAVE_FIELD_WIDTH + SAMPLE_FIELD_WIDTH;
    localparam int SAMPLE_WIDTH_DEF   = 12;
    localparam int NUM_VOICES_DEF     = 4;
    // Wide enough for the largest supported voice count (8)
    localparam int VOICE_IDX_WIDTH    = 3;

    typedef enum logic [1:0] {
        RAM_IDLE  = 2'd0,
        RAM_READ  = 2'd1,
        RAM_WRITE = 2'd2
    } ram_op_e;

    typedef struct packed {
        logic                       valid;
        logic [VOICE_IDX_WIDTH-1:0] voice;
    } read_tag_t;

endpackage
`default_nettype wire

// File: rtl/waveram_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : round-robin pick of the first requester at or after i_pointer
// Revision 1.0
// ============================================================================
module rr_arbiter
    import waveram_arbiter_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEF
) (
    input  logic [NUM_VOICES-1:0]      i_req,
    input  logic [VOICE_IDX_WIDTH-1:0] i_pointer,
    output logic [NUM_VOICES-1:0]      o_grant
);

    logic [NUM_VOICES-1:0] w_mask;
    logic [NUM_VOICES-1:0] w_masked;
    logic [NUM_VOICES-1:0] w_pick;

    // Requests at or above the pointer go first; wrap to the full set otherwise
    always_comb begin
        w_mask = '0;
        for (int k = 0; k < NUM_VOICES; k++) begin
            w_mask[k] = (k >= int'(i_pointer));
        end
        w_masked = i_req & w_mask;
        w_pick   = (|w_masked) ? w_masked : i_req;
        o_grant  = w_pick & (-w_pick);
    end

endmodule
`default_nettype wire

// File: rtl/waveram_arbiter.sv
`default_nettype none
// ============================================================================
// waveram_arbiter : shares one wavetable RAM port between voice reads and host loads
// Revision 1.0
// ============================================================================
module waveram_arbiter
    import waveram_arbiter_pkg::*;
#(
    parameter int NUM_VOICES    = NUM_VOICES_DEF,
    parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
    parameter int SAMPLE_WIDTH  = SAMPLE_WIDTH_DEF,
    parameter int RAM_LATENCY   = 1,
    parameter int HOST_MAX_WAIT = 8
) (
    input  logic                               i_clock,
    input  logic                               i_reset,
    input  logic [NUM_VOICES-1:0]              i_voice_req,
    input  logic [NUM_VOICES*ADDR_WIDTH-1:0]   i_voice_addr,
    output logic [NUM_VOICES-1:0]              o_voice_grant,
    output logic [NUM_VOICES*SAMPLE_WIDTH-1:0] o_voice_sample,
    output logic [NUM_VOICES-1:0]              o_voice_sample_valid,
    input  logic                               i_host_wr_valid,
    output logic                               o_host_wr_ready,
    input  logic [ADDR_WIDTH-1:0]              i_host_wr_addr,
    input  logic [SAMPLE_WIDTH-1:0]            i_host_wr_data,
    output logic [ADDR_WIDTH-1:0]              o_ram_addr,
    output logic                               o_ram_we,
    output logic [SAMPLE_WIDTH-1:0]            o_ram_wdata,
    input  logic [SAMPLE_WIDTH-1:0]            i_ram_rdata
);

    localparam int                c_wait_w   = $clog2(HOST_MAX_WAIT + 2);
    localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(HOST_MAX_WAIT);

    logic [VOICE_IDX_WIDTH-1:0] pointer_q, pointer_d;
    logic [c_wait_w-1:0]        wait_q, wait_d;
    logic [ADDR_WIDTH-1:0]      ram_addr_q, ram_addr_d;
    logic                       ram_we_q, ram_we_d;
    logic [SAMPLE_WIDTH-1:0]    ram_wdata_q, ram_wdata_d;
    read_tag_t                  tag_q [RAM_LATENCY+1];
    read_tag_t                  tag_d;
    logic [SAMPLE_WIDTH-1:0]    sample_q [NUM_VOICES];
    logic [SAMPLE_WIDTH-1:0]    sample_d [NUM_VOICES];

    logic [NUM_VOICES-1:0]      w_rr_grant;
    logic                       w_any_req;
    ram_op_e                    w_op;
    logic [VOICE_IDX_WIDTH-1:0] w_grant_idx;
    logic [ADDR_WIDTH-1:0]      w_grant_addr;
    read_tag_t                  w_ret;

    rr_arbiter #(
        .NUM_VOICES (NUM_VOICES)
    ) u_rr_arbiter (
        .i_req      (i_voice_req),
        .i_pointer  (pointer_q),
        .o_grant    (w_rr_grant)
    );

    assign w_any_req = |i_voice_req;

    // A waiting host only beats voices once it has been starved for HOST_MAX_WAIT cycles
    always_comb begin
        w_op = RAM_IDLE;
        if (!i_reset) begin
            if (i_host_wr_valid && (!w_any_req || wait_q == c_wait_max)) begin
                w_op = RAM_WRITE;
            end else if (w_any_req) begin
                w_op = RAM_READ;
            end
        end
    end

    always_comb begin
        w_grant_idx  = '0;
        w_grant_addr = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (w_rr_grant[v]) begin
                w_grant_idx  = VOICE_IDX_WIDTH'(v);
                w_grant_addr = i_voice_addr[v*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    always_comb begin
        pointer_d   = pointer_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        tag_d       = '0;
        case (w_op)
            RAM_READ: begin
                ram_addr_d = w_grant_addr;
                tag_d      = '{valid: 1'b1, voice: w_grant_idx};
                pointer_d  = (w_grant_idx == VOICE_IDX_WIDTH'(NUM_VOICES - 1)) ?
                             '0 : w_grant_idx + VOICE_IDX_WIDTH'(1);
            end
            RAM_WRITE: begin
                ram_addr_d  = i_host_wr_addr;
                ram_we_d    = 1'b1;
                ram_wdata_d = i_host_wr_data;
            end
            default: ;
        endcase

        wait_d = wait_q;
        if (!i_host_wr_valid || w_op == RAM_WRITE) begin
            wait_d = '0;
        end else if (wait_q != c_wait_max) begin
            wait_d = wait_q + c_wait_w'(1);
        end
    end

    // The oldest tag lines up with i_ram_rdata; the sample bypasses into the output that cycle
    assign w_ret = tag_q[RAM_LATENCY];

    always_comb begin
        sample_d             = sample_q;
        o_voice_sample_valid = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (!i_reset && w_ret.valid && w_ret.voice == VOICE_IDX_WIDTH'(v)) begin
                o_voice_sample_valid[v] = 1'b1;
                sample_d[v]             = i_ram_rdata;
            end
        end
        o_voice_sample = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            o_voice_sample[v*SAMPLE_WIDTH +: SAMPLE_WIDTH] = sample_d[v];
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            pointer_q   <= '0;
            wait_q      <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            for (int k = 0; k <= RAM_LATENCY; k++) begin
                tag_q[k] <= '0;
            end
            for (int v = 0; v < NUM_VOICES; v++) begin
                sample_q[v] <= '0;
            end
        end else begin
            pointer_q   <= pointer_d;
            wait_q      <= wait_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            tag_q[0]    <= tag_d;
            for (int k = 1; k <= RAM_LATENCY; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
            for (int v = 0; v < NUM_VOICES; v++) begin
                sample_q[v] <= sample_d[v];
            end
        end
    end

    assign o_voice_grant   = (w_op == RAM_READ) ? w_rr_grant : '0;
    assign o_host_wr_ready = (w_op == RAM_WRITE);
    assign o_ram_addr      = ram_addr_q;
    assign o_ram_we        = ram_we_q;
    assign o_ram_wdata     = ram_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_waveram_arbiter.sv
`default_nettype none
// ============================================================================
// tb_waveram_arbiter : directed checks of waveram_arbiter against a 1-cycle RAM model
// Revision 1.0
// ============================================================================
module tb_waveram_arbiter;

    localparam int NV = 4;
    localparam int AW = 13;
    localparam int SW = 12;

    logic          clock = 1'b0;
    logic          reset;
    logic [NV-1:0] voice_req;
    logic [NV*AW-1:0] voice_addr;
    logic [NV-1:0] voice_grant;
    logic [NV*SW-1:0] voice_sample;
    logic [NV-1:0] voice_sample_valid;
    logic          host_wr_valid;
    logic          host_wr_ready;
    logic [AW-1:0] host_wr_addr;
    logic [SW-1:0] host_wr_data;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [SW-1:0] ram_wdata;
    logic [SW-1:0] ram_rdata = '0;

    logic [SW-1:0] mem [0:(1<<AW)-1];

    logic [31:0] s_grant, s_valid, s_ready, s_we, s_addr, s_wdata;
    logic [31:0] s_sample [NV];
    bit          hold_req;
    int          n_checks = 0;
    int          n_fail   = 0;

    waveram_arbiter #(
        .NUM_VOICES    (NV),
        .ADDR_WIDTH    (AW),
        .SAMPLE_WIDTH  (SW),
        .RAM_LATENCY   (1),
        .HOST_MAX_WAIT (8)
    ) dut (
        .i_clock              (clock),
        .i_reset              (reset),
        .i_voice_req          (voice_req),
        .i_voice_addr         (voice_addr),
        .o_voice_grant        (voice_grant),
        .o_voice_sample       (voice_sample),
        .o_voice_sample_valid (voice_sample_valid),
        .i_host_wr_valid      (host_wr_valid),
        .o_host_wr_ready      (host_wr_ready),
        .i_host_wr_addr       (host_wr_addr),
        .i_host_wr_data       (host_wr_data),
        .o_ram_addr           (ram_addr),
        .o_ram_we             (ram_we),
        .o_ram_wdata          (ram_wdata),
        .i_ram_rdata          (ram_rdata)
    );

    always #5 clock = ~clock;

    // Single-port RAM, read data one cycle after the address is presented
    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int v, input logic [AW-1:0] a);
        voice_addr[v*AW +: AW] = a;
    endtask

    // Sample one cycle's outputs mid-cycle, then retire granted/accepted requests
    task automatic cycle();
        @(negedge clock);
        s_grant = 32'(voice_grant);
        s_valid = 32'(voice_sample_valid);
        s_ready = 32'(host_wr_ready);
        s_we    = 32'(ram_we);
        s_addr  = 32'(ram_addr);
        s_wdata = 32'(ram_wdata);
        for (int v = 0; v < NV; v++) s_sample[v] = 32'(voice_sample[v*SW +: SW]);
        @(posedge clock);
        #1;
        if (!hold_req) voice_req = voice_req & ~s_grant[NV-1:0];
        if (s_ready[0]) host_wr_valid = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) mem[a] = 12'(a) ^ 12'h5A5;
        reset = 1'b1; voice_req = '0; voice_addr = '0; hold_req = 1'b0;
        host_wr_valid = 1'b0; host_wr_addr = '0; host_wr_data = '0;
        @(posedge clock);
        #1;
        cycle();
        cycle();
        check("rst_grant", s_grant, 0);
        check("rst_valid", s_valid, 0);
        check("rst_ready", s_ready, 0);
        check("rst_we",    s_we,    0);
        check("rst_addr",  s_addr,  0);
        check("rst_wdata", s_wdata, 0);

        // All voices at once: strict rotation, data two cycles after grant
        reset = 1'b0; voice_req = 4'b1111;
        set_addr(0, 13'h000); set_addr(1, 13'h080); set_addr(2, 13'h100); set_addr(3, 13'h180);
        cycle(); check("rr_c0_grant", s_grant, 'h1); check("rr_c0_valid", s_valid, 0);
        cycle(); check("rr_c1_grant", s_grant, 'h2); check("rr_c1_valid", s_valid, 0);
                 check("rr_c1_raddr", s_addr, 'h000); check("rr_c1_we", s_we, 0);
        cycle(); check("rr_c2_grant", s_grant, 'h4); check("rr_c2_valid", s_valid, 'h1);
                 check("rr_c2_s0", s_sample[0], 'h5A5); check("rr_c2_raddr", s_addr, 'h080);
        cycle(); check("rr_c3_grant", s_grant, 'h8); check("rr_c3_valid", s_valid, 'h2);
                 check("rr_c3_s1", s_sample[1], 'h525);
        cycle(); check("rr_c4_grant", s_grant, 0);   check("rr_c4_valid", s_valid, 'h4);
                 check("rr_c4_s2", s_sample[2], 'h4A5);
        cycle(); check("rr_c5_valid", s_valid, 'h8); check("rr_c5_s3", s_sample[3], 'h425);
                 check("rr_c5_s0_held", s_sample[0], 'h5A5);

        // Host load with voices idle, then read it back through voice 1
        host_wr_valid = 1'b1; host_wr_addr = 13'h005; host_wr_data = 12'hABC;
        cycle(); check("hw_ready", s_ready, 1); check("hw_grant", s_grant, 0);
        cycle(); check("hw_we", s_we, 1); check("hw_addr", s_addr, 'h005);
                 check("hw_wdata", s_wdata, 'hABC); check("hw_valid", s_valid, 0);
        voice_req = 4'b0010; set_addr(1, 13'h005);
        cycle(); check("rb_grant", s_grant, 'h2);
        cycle(); check("rb_raddr", s_addr, 'h005); check("rb_we", s_we, 0);
        cycle(); check("rb_valid", s_valid, 'h2); check("rb_s1", s_sample[1], 'hABC);
        cycle(); check("idle_we", s_we, 0); check("idle_addr", s_addr, 'h005);
                 check("idle_valid", s_valid, 0);

        // Starved host forced through on its 9th valid cycle; rotation resumes at v2
        hold_req = 1'b1; voice_req = 4'b1111;
        host_wr_valid = 1'b1; host_wr_addr = 13'h010; host_wr_data = 12'h123;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check($sformatf("starve_c%0d_grant", i), s_grant, 1 << ((2 + i) % 4));
            check($sformatf("starve_c%0d_ready", i), s_ready, 0);
        end
        cycle(); check("force_ready", s_ready, 1); check("force_grant", s_grant, 0);
        cycle(); check("resume_grant", s_grant, 'h4); check("force_we", s_we, 1);
                 check("force_addr", s_addr, 'h010); check("force_wdata", s_wdata, 'h123);
        cycle(); check("resume_grant2", s_grant, 'h8);
        hold_req = 1'b0; voice_req = '0;
        cycle(); cycle(); cycle();

        // Reset one cycle after a v2 grant discards that read
        voice_req = 4'b0100;
        cycle(); check("rst2_grant_v2", s_grant, 'h4);
        reset = 1'b1;
        cycle();
        reset = 1'b0; voice_req = 4'b1111;
        cycle(); check("rst2_valid", s_valid, 0); check("rst2_next_grant", s_grant, 'h1);
                 check("rst2_we", s_we, 0); check("rst2_addr", s_addr, 0);
                 check("rst2_wdata", s_wdata, 0); check("rst2_ready", s_ready, 0);
        for (int v = 0; v < NV; v++) check($sformatf("rst2_s%0d", v), s_sample[v], 0);
        voice_req = '0;
        cycle(); cycle(); cycle();

        // v3 re-requests exactly as its first read returns
        voice_req = 4'b1000; set_addr(3, 13'h180);
        cycle(); check("rr3_grant_a", s_grant, 'h8);
        cycle(); check("rr3_gap_valid", s_valid, 0);
        voice_req = 4'b1000; set_addr(3, 13'h005);
        cycle(); check("rr3_grant_b", s_grant, 'h8); check("rr3_valid_a", s_valid, 'h8);
                 check("rr3_s3_a", s_sample[3], 'h425);
        cycle(); check("rr3_hold_valid", s_valid, 0); check("rr3_s3_held", s_sample[3], 'h425);
        cycle(); check("rr3_valid_b", s_valid, 'h8); check("rr3_s3_b", s_sample[3], 'hABC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/waveram_arbiter.md
WAVERAM_ARBITER -- requirements
Module: waveram_arbiter

Interface
REQ-001 Parameter NUM_VOICES, default 4: number of voice (NCO) requesters, range 2..8.
REQ-002 Parameter ADDR_WIDTH, default 13: wavetable RAM address width (6-bit wave + 7-bit sample).
REQ-003 Parameter SAMPLE_WIDTH, default 12: wavetable sample width.
REQ-004 Parameter RAM_LATENCY, default 1: cycles from RAM address presentation to valid i_ram_rdata, range 1..3.
REQ-005 Parameter HOST_MAX_WAIT, default 8: cycles a pending host write may be deferred before forced service.
REQ-006 i_clock  in  1  system clock; all logic on posedge.
REQ-007 i_reset  in  1  synchronous, active-high reset.
REQ-008 i_voice_req  in  NUM_VOICES  per-voice read request, level, held until granted.
REQ-009 i_voice_addr  in  NUM_VOICES*ADDR_WIDTH  per-voice RAM address, voice v at slice v.
REQ-010 o_voice_grant  out  NUM_VOICES  one-hot, one-cycle pulse: voice address accepted this cycle.
REQ-011 o_voice_sample  out  NUM_VOICES*SAMPLE_WIDTH  per-voice held sample register.
REQ-012 o_voice_sample_valid  out  NUM_VOICES  one-cycle pulse: corresponding o_voice_sample updated.
REQ-013 i_host_wr_valid / o_host_wr_ready  in/out  1/1  host wavetable-load handshake; transfer when both high.
REQ-014 i_host_wr_addr, i_host_wr_data  in  ADDR_WIDTH / SAMPLE_WIDTH  host write address and data.
REQ-015 o_ram_addr, o_ram_we, o_ram_wdata  out  ADDR_WIDTH / 1 / SAMPLE_WIDTH  single-port RAM command, registered.
REQ-016 i_ram_rdata  in  SAMPLE_WIDTH  RAM read data, valid RAM_LATENCY cycles after read command.

Function
REQ-017 Exactly one RAM access (read or write) or idle per cycle; arbitration decided combinationally, RAM command registered, issued next cycle.
REQ-018 Voice arbitration: round-robin; pointer starts at voice 0, moves to granted voice+1 (mod NUM_VOICES) after each voice grant.
REQ-019 Host write wins when no voice request is pending, or when host wait counter equals HOST_MAX_WAIT; otherwise voices win.
REQ-020 Host wait counter: increments each cycle i_host_wr_valid high and not ready; clears on host transfer or i_host_wr_valid low; saturates at HOST_MAX_WAIT.
REQ-021 o_host_wr_ready combinational, high only in cycles host wins; no voice grant same cycle.
REQ-022 Granted voice address captured in grant cycle; voice must drop or change request after grant (new request = new read).
REQ-023 Read tag pipeline (valid + voice index) depth RAM_LATENCY+1; at tag exit, i_ram_rdata written to that voice's o_voice_sample, valid pulse asserted same cycle.
REQ-024 Grant-to-sample_valid latency fixed at RAM_LATENCY+1 cycles; throughput one read per cycle.
REQ-025 Write cycles insert no tag; never produce sample_valid.
REQ-026 Returning data and new grant for same voice in same cycle both honoured; no data loss.
REQ-027 Idle cycles drive o_ram_we=0, o_ram_addr unchanged.

Reset
REQ-028 On i_reset: grants, sample_valid, ready, o_ram_we = 0; o_ram_addr, o_ram_wdata = 0; all o_voice_sample = 0; pointer = 0; wait counter = 0; tag pipeline cleared.
REQ-029 Reset mid-operation discards in-flight reads: no sample_valid for reads issued before reset.
REQ-030 First grant possible in first cycle after i_reset deasserts.

Structure
REQ-031 Shared package holds ADDR_WIDTH, SAMPLE_WIDTH, NUM_VOICES defaults and wave/sample address field widths (6/7), shared with the NCO.
REQ-032 One sub-module: rr_arbiter (NUM_VOICES-wide round-robin, req/pointer in, one-hot grant out).

Verification
REQ-033 All 4 voices request from cycle 0 post-reset, addrs 0x000/0x080/0x100/0x180 -> grants v0,v1,v2,v3 cycles 0..3; sample_valid v0..v3 cycles 2..5 (RAM_LATENCY=1).
REQ-034 Host write addr 0x005 data 0xABC, voices idle -> ready same cycle; later v1 read 0x005 -> o_voice_sample[1]=0xABC.
REQ-035 Voices continuously requesting, host valid held, HOST_MAX_WAIT=8 -> host transfer on 9th cycle of valid, then round-robin resumes at correct voice.
REQ-036 Reset asserted 1 cycle after v2 grant -> no v2 sample_valid; all outputs zero; next grant v0.
REQ-037 v3 re-requests in cycle its previous data returns -> both grant and sample_valid same cycle; second read data correct.
